gray_step_monitor: RTL

- Downstream consumer of the binary-to-Gray converter stage.
- Samples a qualified Gray-coded word stream, decodes each word back to binary, and checks that successive samples differ in exactly one bit.
- Reports step direction, keeps a saturating error count, and asserts a lock flag after a run of clean steps.
- Used to verify converter and counter pipelines in-system.

---
 rtl/gray_pkg.sv | 44 ++++
 rtl/gray_to_binary.sv | 23 ++
 rtl/gray_step_monitor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared definitions for the Gray-code step monitor.
//   GRAY_WIDTH  - default Gray/binary word width
//   GRAY_MAX_W  - widest word the helper functions handle
//   state_e     - monitor state (IDLE: no reference yet, TRACK: reference held)
//   gray2bin()  - Gray to binary decode of the low 'w' bits of a GRAY_MAX_W word
//   popcount()  - number of set bits in a GRAY_MAX_W word
package gray_pkg;

  localparam int GRAY_WIDTH = 4;
  localparam int GRAY_MAX_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_e;

  // Bits at or above 'w' are masked off first, so the MSB-down xor chain
  // starts at bit w-1 and the upper result bits come out zero.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int w);
    logic [GRAY_MAX_W-1:0] gm;
    logic [GRAY_MAX_W-1:0] b;
    gm = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      if (i < w) gm[i] = g[i];
    end
    b = '0;
    b[GRAY_MAX_W-1] = gm[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

  function automatic int popcount(input logic [GRAY_MAX_W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// gray_to_binary: combinational Gray-to-binary decoder, the inverse of the
// upstream binary-to-Gray converter.
//   gray_i [WIDTH-1:0] - Gray-coded word
//   bin_o  [WIDTH-1:0] - decoded binary word
module gray_to_binary
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the xor of all Gray bits at or above it.
  always_comb begin
    bin_o = '0;
    bin_o[WIDTH-1] = gray_i[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/gray_step_monitor.sv
// gray_step_monitor: checks a qualified Gray-coded stream for single-bit steps.
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in_valid, in_gray   - sample qualifier and Gray-coded sample
//   clear               - synchronous clear of state and counters (wins over in_valid)
//   out_valid, out_bin  - one-cycle pulse with the decoded binary of the accepted sample
//   step_ok / step_err  - sample differed from the previous one by 1 / by 2+ bits
//   step_up             - with step_ok: 1 = +1 mod 2^WIDTH, 0 = -1
//   err_count           - saturating count of step_err events
//   locked              - LOCK_N consecutive good steps since last error/clear/reset
// Interface: no backpressure. A sample is accepted on every rising edge where
// in_valid is high and clear is low; its results appear on the outputs for
// exactly the following cycle, qualified by out_valid.
module gray_step_monitor
  import gray_pkg::*;
#(
  parameter int WIDTH  = GRAY_WIDTH,
  parameter int ERR_W  = 8,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_gray,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic             step_ok,
  output logic             step_err,
  output logic             step_up,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  localparam int RUN_W = 8;
  localparam logic [RUN_W-1:0] LOCK_CNT = RUN_W'(LOCK_N);
  localparam logic [GRAY_MAX_W-1:0] WMASK =
    (WIDTH >= GRAY_MAX_W) ? '1 : ((GRAY_MAX_W'(1) << WIDTH) - GRAY_MAX_W'(1));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;
  logic             step_ok_q, step_ok_d;
  logic             step_err_q, step_err_d;
  logic             step_up_q, step_up_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             locked_q, locked_d;

  logic [WIDTH-1:0] in_bin;
  int               diff;

  gray_to_binary #(.WIDTH(WIDTH)) u_dec (
    .gray_i (in_gray),
    .bin_o  (in_bin)
  );

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    out_valid_d = 1'b0;
    out_bin_d   = '0;
    step_ok_d   = 1'b0;
    step_err_d  = 1'b0;
    step_up_d   = 1'b0;
    err_d       = err_q;
    run_d       = run_q;
    locked_d    = locked_q;
    diff        = popcount(GRAY_MAX_W'(in_gray ^ ref_q));

    if (clear) begin
      state_d  = IDLE;
      ref_d    = '0;
      err_d    = '0;
      run_d    = '0;
      locked_d = 1'b0;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      out_bin_d   = in_bin;
      ref_d       = in_gray;
      state_d     = TRACK;
      if (state_q == TRACK) begin
        if (diff == 1) begin
          step_ok_d = 1'b1;
          // Compare against the decoded reference + 1 in WIDTH-bit arithmetic
          // so the 15 -> 0 wrap counts as an up step.
          step_up_d = (GRAY_MAX_W'(in_bin) ==
                       ((gray2bin(GRAY_MAX_W'(ref_q), WIDTH) + GRAY_MAX_W'(1)) & WMASK));
          if (run_q < LOCK_CNT) run_d = run_q + RUN_W'(1);
          locked_d = (run_d == LOCK_CNT);
        end else if (diff >= 2) begin
          step_err_d = 1'b1;
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          run_d    = '0;
          locked_d = 1'b0;
        end
        // diff == 0: repeated sample, run and lock hold.
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ref_q       <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      step_ok_q   <= 1'b0;
      step_err_q  <= 1'b0;
      step_up_q   <= 1'b0;
      err_q       <= '0;
      run_q       <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      step_ok_q   <= step_ok_d;
      step_err_q  <= step_err_d;
      step_up_q   <= step_up_d;
      err_q       <= err_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign step_ok   = step_ok_q;
  assign step_err  = step_err_q;
  assign step_up   = step_up_q;
  assign err_count = err_q;
  assign locked    = locked_q;

endmodule
